// File: rtl/charbuf_pkg.sv
// Shared definitions for the character-buffer access scheduler.
// Holds geometry defaults, address helpers and clear-engine state codes.
package charbuf_pkg;

  localparam int         CB_COLS  = 70;
  localparam int         CB_ROWS  = 30;
  localparam logic [7:0] CB_BLANK = 8'h00;

  // Clear-engine state codes
  localparam logic [1:0] CLR_IDLE  = 2'd0;
  localparam logic [1:0] CLR_CLEAR = 2'd1;
  localparam logic [1:0] CLR_DONE  = 2'd2;

  // RAM address layout: column in the high bits, physical row in the low bits.
  function automatic logic [11:0] pack_addr(input logic [6:0] col, input logic [4:0] row);
    pack_addr = {col, row};
  endfunction

  // Scrolling is a 5-bit rotate of the row index; the wrap is intentional.
  function automatic logic [4:0] phys_row(input logic [4:0] row, input logic [4:0] offset);
    phys_row = 5'(row + offset);
  endfunction

endpackage

// File: rtl/charbuf_clear_engine.sv
// Blanks one logical row, one column per granted step; requests a slot while clearing.
// Steps stall without loss whenever step_grant is low; a new request is taken only when idle.
module charbuf_clear_engine
  import charbuf_pkg::*;
#(
  parameter int COLS = CB_COLS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  line_offset,
  input  logic        clr_req,
  input  logic [4:0]  clr_row,
  input  logic        step_grant,
  output logic        step_req,
  output logic [11:0] step_addr,
  output logic [4:0]  busy_row,
  output logic        clr_busy,
  output logic        clr_done
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  logic [1:0] state;
  logic [6:0] col;
  logic [4:0] row_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      col   <= '0;
      row_q <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clr_req) begin
            state <= CLR_CLEAR;
            col   <= '0;
            row_q <= clr_row;
          end
        end
        CLR_CLEAR: begin
          if (step_grant) begin
            if (col == LAST_COL) begin
              state <= CLR_DONE;
              col   <= '0;
            end else begin
              col <= col + 7'd1;
            end
          end
        end
        CLR_DONE: state <= CLR_IDLE;
        default:  state <= CLR_IDLE;
      endcase
    end
  end

  // Offset is applied per step, so the target row follows line_offset live.
  assign step_req  = (state == CLR_CLEAR);
  assign step_addr = pack_addr(col, phys_row(row_q, line_offset));
  assign busy_row  = row_q;
  assign clr_busy  = (state == CLR_CLEAR);
  assign clr_done  = (state == CLR_DONE);

endmodule

// File: rtl/charbuf_sched.sv
// Time-slots the single-port character RAM between VGA reads, editor writes and row clears.
// VGA data two cycles after grant; editor writes ack in the grant cycle and stall on the row being cleared.
module charbuf_sched
  import charbuf_pkg::*;
#(
  parameter int         COLS  = CB_COLS,
  parameter int         ROWS  = CB_ROWS,
  parameter logic [7:0] BLANK = CB_BLANK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  line_offset,
  input  logic        vga_req,
  input  logic [6:0]  vga_col,
  input  logic [4:0]  vga_row,
  output logic [7:0]  vga_data,
  output logic        vga_valid,
  input  logic        wr_req,
  input  logic [6:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        clr_req,
  input  logic [4:0]  clr_row,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  logic        phase;
  logic        step_req;
  logic        step_grant;
  logic [11:0] step_addr;
  logic [4:0]  busy_row;
  logic        vga_in_range;
  logic        wr_in_range;
  logic        wr_ok;
  logic        vga_gnt;
  logic        wr_gnt;
  logic [11:0] addr_q;
  logic        rd_pend;
  logic        rd_in_range;

  charbuf_clear_engine #(
    .COLS (COLS)
  ) u_clear (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_offset (line_offset),
    .clr_req     (clr_req),
    .clr_row     (clr_row),
    .step_grant  (step_grant),
    .step_req    (step_req),
    .step_addr   (step_addr),
    .busy_row    (busy_row),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done)
  );

  assign vga_in_range = (int'(vga_col) < COLS) && (int'(vga_row) < ROWS);
  assign wr_in_range  = (int'(wr_col) < COLS);

  // An editor write to the row under clear waits so the clear cannot overwrite it.
  assign wr_ok = wr_req && !(clr_busy && (wr_row == busy_row));

  // Phase 0 belongs to VGA; an unused VGA slot falls through to write/clear.
  assign vga_gnt    = rst_n && !phase && vga_req;
  assign wr_gnt     = rst_n && !vga_gnt && wr_ok;
  assign step_grant = rst_n && !vga_gnt && !wr_ok && step_req;
  assign wr_ack     = wr_gnt;

  always_comb begin
    ram_addr = addr_q;
    ram_we   = 1'b0;
    ram_din  = 8'h00;
    if (vga_gnt) begin
      if (vga_in_range) ram_addr = pack_addr(vga_col, phys_row(vga_row, line_offset));
    end else if (wr_gnt) begin
      if (wr_in_range) begin
        ram_addr = pack_addr(wr_col, phys_row(wr_row, line_offset));
        ram_we   = 1'b1;
        ram_din  = wr_data;
      end
    end else if (step_grant) begin
      ram_addr = step_addr;
      ram_we   = 1'b1;
      ram_din  = BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase       <= 1'b0;
      addr_q      <= '0;
      rd_pend     <= 1'b0;
      rd_in_range <= 1'b0;
      vga_valid   <= 1'b0;
      vga_data    <= 8'h00;
    end else begin
      phase       <= ~phase;
      addr_q      <= ram_addr;
      rd_pend     <= vga_gnt;
      rd_in_range <= vga_in_range;
      vga_valid   <= rd_pend;
      if (rd_pend) vga_data <= rd_in_range ? ram_dout : 8'h00;
    end
  end

endmodule

// File: doc/charbuf_sched.md
# charbuf_sched

Single-port access scheduler for the 4096×8 text character buffer. Logical (column, row) addresses are mapped to physical addresses through the scroll offset. The block shares the buffer between three requesters:

- the VGA character fetch (read),
- the keyboard editor (single-character write),
- a built-in line-clear engine that blanks a whole row after a scroll.

It sits between the editor/VGA logic and the block-RAM instance, and owns the RAM address, write-enable and data pins.

## Interface
Parameters:
- COLS, 70, visible columns per line; valid column range 0..COLS-1
- ROWS, 30, visible lines
- BLANK, 8'h00, byte written by the clear engine

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst_n  in  1  reset, synchronous, active-low
- line_offset  in  5  scroll offset; physical row = (row + line_offset) mod 32
- vga_req  in  1  VGA fetch request (level)
- vga_col  in  7  VGA logical column
- vga_row  in  5  VGA logical row
- vga_data  out  8  fetched character
- vga_valid  out  1  one-cycle pulse; vga_data updated this cycle
- wr_req  in  1  editor write request; held until wr_ack
- wr_col  in  7  write column
- wr_row  in  5  write logical row
- wr_data  in  8  character to write
- wr_ack  out  1  one-cycle pulse in the cycle the write is issued
- clr_req  in  1  start clearing one logical row (pulse)
- clr_row  in  5  logical row to clear
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse after the last column is written
- ram_addr  out  12  {col[6:0], phys_row[4:0]}
- ram_we  out  1  RAM write enable
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data, valid one cycle after the read address

## Operation
- phase register: resets to 0 and toggles every cycle. Phase 0 is the VGA slot; phase 1 is the write slot.
- Grant per cycle (exactly one or none), evaluated combinationally; ram_addr, ram_we and ram_din are driven in the same cycle:
  - Phase 0: if vga_req, grant VGA read. Otherwise fall through to the phase-1 order (work-conserving).
  - Phase 1: editor write first, then one clear-engine step, else idle. Idle means ram_we=0 and ram_addr holds its last value.
- Editor write:
  - If wr_col ≥ COLS, the write is suppressed (ram_we=0) but wr_ack still pulses.
  - If clr_busy is high and wr_row equals the row being cleared, wr_ack is withheld until clr_done.
- Clear engine, states IDLE → CLEAR → DONE → IDLE:
  - clr_req is accepted only in IDLE. It latches clr_row, sets the column counter to 0 and raises clr_busy.
  - Each granted step writes BLANK at (col, latched row) and increments col.
  - After the write at col = COLS-1: go to DONE, pulse clr_done, drop clr_busy, return to IDLE.
  - clr_req while busy is ignored; no queueing.
  - The physical row is recomputed each step from the current line_offset. Software must not change line_offset mid-clear.
- VGA read:
  - If vga_col ≥ COLS or vga_row ≥ ROWS, no RAM read is issued; vga_data=8'h00 with vga_valid following normal latency.
  - Otherwise ram_dout is registered into vga_data.
- Row arithmetic is 5-bit with natural wrap (29+5 = 2).

## Timing
- Reset values: phase=0, state IDLE, col counter 0, vga_data=8'h00, vga_valid=0, wr_ack=0, clr_busy=0, clr_done=0, ram_we=0, ram_addr=0, ram_din=0.
- Reset asserted mid-clear aborts the clear immediately. No clr_done is issued, and the row stays partially blank.
- VGA latency: read granted in cycle N, ram_dout valid in N+1, vga_data/vga_valid presented in N+2. vga_data holds until the next valid.
- Write latency: wr_ack asserts in the grant cycle. The requester may change wr_* in the following cycle.
- Clear duration with a continuous VGA load and no editor writes: COLS writes at one per 2 cycles, so clr_done arrives 2·COLS cycles after acceptance (±1 for phase alignment).
- Simultaneous clr_req and clear completion: the new request is ignored, because the state is not IDLE in that cycle.
- Simultaneous wr_req and a clear step in phase 1: the write wins and the clear column does not advance.

## Structure
- Shared package (charbuf_pkg):
  - COLS, ROWS, BLANK
  - address pack function {col, row}
  - phys_row function (row + offset, 5-bit)
  - clear-state enum
- One sub-module: charbuf_clear_engine, containing the clear FSM and column counter. It presents step_req/step_addr and accepts step_grant.
- Top level holds phase, the grant mux and the VGA return pipeline.

## Test plan
- Reset then vga_req=1, vga_col=3, vga_row=2, line_offset=0: ram_addr=12'h062 on phase-0 cycles; vga_data equals the preloaded byte 2 cycles after grant.
- wr_req with col 5, row 29, line_offset 4, data 8'h41: one phase-1 cycle with ram_we=1, ram_addr={5, 5'd1}, and wr_ack that same cycle.
- clr_req with row 10 and continuous vga_req: exactly 70 BLANK writes to cols 0..69; clr_done after 140±1 cycles; clr_busy low afterwards.
- During a clear of row 10: wr_req to row 10 is stalled until clr_done, then acked. wr_req to row 11 is acked within 2 cycles and the clear takes one extra slot.
- wr_col=75: wr_ack pulses with ram_we=0. vga_col=72: vga_data=8'h00.
- rst_n low at clear column 30: clr_busy=0 next cycle, no clr_done, columns 30..69 untouched.
